// File: rtl/dmaster_packets_to_bytes.sv
// Serialises a channelised 8-bit Avalon-ST packet stream into a flat byte stream
// framed with in-band 0x7A/0x7B/0x7C markers and 0x7D escapes.
module dmaster_packets_to_bytes #(
   parameter int CHANNEL_WIDTH  = 8,
   parameter bit ENCODE_CHANNEL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data
);

   typedef enum logic [2:0] {
      IDLE, CH_MARK, CH_ESC, CH_VAL, SOP_MARK, EOP_MARK, D_ESC, D_VAL
   } state_t;

   state_t     state;
   logic [7:0] hold_data;
   logic [7:0] hold_channel;
   logic       hold_sop;
   logic       hold_eop;
   logic [7:0] last_channel;
   logic [7:0] channel_byte;
   logic       accept;
   logic       out_fire;

   function automatic logic is_reserved(input logic [7:0] b);
      return (b >= 8'h7A) && (b <= 8'h7D);
   endfunction

   function automatic state_t data_state(input logic [7:0] d);
      return is_reserved(d) ? D_ESC : D_VAL;
   endfunction

   function automatic state_t after_header(input logic sop, input logic eop,
                                           input logic [7:0] d);
      if (sop)
         return SOP_MARK;
      else if (eop)
         return EOP_MARK;
      else
         return data_state(d);
   endfunction

   // A header is needed on every SOP and whenever the channel differs from the last one sent.
   function automatic state_t first_state(input logic sop, input logic eop,
                                          input logic [7:0] ch, input logic [7:0] d,
                                          input logic [7:0] last);
      if (ENCODE_CHANNEL && (sop || (ch != last)))
         return CH_MARK;
      else
         return after_header(sop, eop, d);
   endfunction

   assign channel_byte = ENCODE_CHANNEL ? 8'(in_channel) : 8'h00;
   assign in_ready     = !reset && ((state == IDLE) || ((state == D_VAL) && out_ready));
   assign out_valid    = !reset && (state != IDLE);
   assign accept       = in_valid && in_ready;
   assign out_fire     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         hold_data    <= 8'h00;
         hold_channel <= 8'h00;
         hold_sop     <= 1'b0;
         hold_eop     <= 1'b0;
         last_channel <= 8'h00;
      end else begin
         if (accept) begin
            hold_data    <= in_data;
            hold_channel <= channel_byte;
            hold_sop     <= in_startofpacket;
            hold_eop     <= in_endofpacket;
         end
         case (state)
            IDLE:
               if (accept)
                  state <= first_state(in_startofpacket, in_endofpacket,
                                       channel_byte, in_data, last_channel);
            CH_MARK:
               if (out_fire)
                  state <= is_reserved(hold_channel) ? CH_ESC : CH_VAL;
            CH_ESC:
               if (out_fire)
                  state <= CH_VAL;
            CH_VAL:
               if (out_fire) begin
                  last_channel <= hold_channel;
                  state        <= after_header(hold_sop, hold_eop, hold_data);
               end
            SOP_MARK:
               if (out_fire)
                  state <= hold_eop ? EOP_MARK : data_state(hold_data);
            EOP_MARK:
               if (out_fire)
                  state <= data_state(hold_data);
            D_ESC:
               if (out_fire)
                  state <= D_VAL;
            D_VAL:
               // Final byte handoff may coincide with the next beat, avoiding a bubble.
               if (out_fire) begin
                  if (accept)
                     state <= first_state(in_startofpacket, in_endofpacket,
                                          channel_byte, in_data, last_channel);
                  else
                     state <= IDLE;
               end
            default:
               state <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_data = 8'h00;
      if (!reset) begin
         case (state)
            CH_MARK:  out_data = 8'h7C;
            CH_ESC:   out_data = 8'h7D;
            CH_VAL:   out_data = is_reserved(hold_channel) ? (hold_channel ^ 8'h20) : hold_channel;
            SOP_MARK: out_data = 8'h7A;
            EOP_MARK: out_data = 8'h7B;
            D_ESC:    out_data = 8'h7D;
            D_VAL:    out_data = is_reserved(hold_data) ? (hold_data ^ 8'h20) : hold_data;
            default:  out_data = 8'h00;
         endcase
      end
   end

endmodule

// File: doc/dmaster_packets_to_bytes.md
Name: dmaster_packets_to_bytes

Overview:
- Downstream neighbour of the debug-master packet-to-channel adapter.
- Consumes its channelised Avalon-ST packet stream (8-bit data, SOP/EOP, channel) and serialises it into a flat, unframed byte stream for the JTAG/serial byte transport.
- Framing uses in-band special characters: 0x7A start-of-packet, 0x7B end-of-packet, 0x7C channel marker, 0x7D escape.
- Reserved bytes that occur in data or channel fields are escaped.

Parameters:
- CHANNEL_WIDTH, 8, width of in_channel (1..8); the value is zero-extended to one byte on output.
- ENCODE_CHANNEL, 1, 1 = emit channel headers; 0 = never emit 0x7C or a channel byte, and in_channel is ignored.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_ready  output  1  beat accepted when in_valid and in_ready are both high.
- in_valid  input  1  input beat valid.
- in_data  input  8  payload byte.
- in_startofpacket  input  1  first beat of packet.
- in_endofpacket  input  1  last beat of packet.
- in_channel  input  CHANNEL_WIDTH  channel of beat.
- out_ready  input  1  downstream can take a byte.
- out_valid  output  1  out_data valid.
- out_data  output  8  encoded byte.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high (port reset), sampled on the rising edge of clk.
- While reset is high and on the first cycle after it:
  - out_valid=0, out_data=0x00, in_ready=0 while reset high.
  - FSM goes to IDLE; holding register cleared; last_channel=0.
  - in_ready=1 in IDLE once reset is low.
- Reset mid-operation: any partially emitted beat is discarded. No completion bytes are emitted after reset.
- Beat capture: an accepted beat is latched into a holding register (data, sop, eop, channel). The FSM then emits that beat's byte sequence in fixed order:
  1. Channel header, if ENCODE_CHANNEL=1 and (sop=1 or channel != last_channel): 0x7C, then the channel byte. A reserved channel byte is sent as 0x7D followed by (byte XOR 0x20).
  2. 0x7A, if sop=1.
  3. 0x7B, if eop=1.
  4. Data byte. A reserved data byte (0x7A..0x7D) is sent as 0x7D followed by (data XOR 0x20).
- last_channel updates when the channel byte is emitted.
- FSM states: IDLE, CH_MARK, CH_ESC, CH_VAL, SOP_MARK, EOP_MARK, D_ESC, D_VAL.
  - From IDLE, an accepted beat moves to the first applicable state in the order above; later states are likewise skipped when not applicable.
  - Each state advances only on out_valid && out_ready.
  - The byte emitted in D_VAL is the last byte of the beat.
- Output timing:
  - out_valid=1 in every non-IDLE state; out_data is a function of registered state and the holding register.
  - out_data and out_valid stay stable while out_ready=0.
- in_ready = (state==IDLE) || (state==D_VAL && out_ready). This allows back-to-back acceptance.
  - Simultaneous final-byte handoff and new beat acceptance goes directly to the new beat's first state, with no bubble.
  - Plain data beats with no header and no escape therefore stream at 1 byte/cycle.
- Latency: first output byte appears the cycle after acceptance.
- Channel-change semantics: a channel change on a non-SOP beat (interleaving) still emits the header. SOP always emits the header even if the channel is unchanged.
- The block does not check SOP/EOP protocol. A beat with both sop and eop is legal and emits 0x7A, then 0x7B, then data.

Test Plan:
- After reset, beat {sop=1, eop=1, ch=0, data=0x41}, out_ready=1 -> bytes 7C 00 7A 7B 41 on 5 consecutive cycles; in_ready high again in the cycle the 0x41 handshake completes.
- Packet ch=3: data 0x10 (sop), 0x7B, 0x20 (eop) -> 7C 03 7A 10 7D 5B 7B 20; no channel header before beats 2 and 3.
- Beat {sop=1, ch=0x7D, data=0x7A} -> 7C 7D 5D 7A 7D 5A.
- Four mid-packet plain beats on an unchanged channel, out_ready=1 -> 4 bytes on 4 consecutive cycles with in_ready continuously high.
- out_ready toggling 1,0,0,1 during escape pair 7D 5B -> out_data holds 0x5B stable through the stalled cycles; no byte is duplicated or lost. Scoreboard decodes the output back to the original beats.
- Reset asserted while in SOP_MARK -> next cycle out_valid=0, in_ready=0. After release, next beat {sop=1, ch=0} emits a full header 7C 00 7A ...
